// File: rtl/freq_meas_pkg.sv
// Shared constants for the frequency-measurement sequencer: gate encoding,
// Hz-per-count multipliers and FSM state codes.
package freq_meas_pkg;

  localparam logic GATE_FAST = 1'b1;
  localparam logic GATE_SLOW = 1'b0;

  // Hz per count: 1 / 50 us and 1 / 50 ms
  localparam logic [15:0] FAST_MULT = 16'd20000;
  localparam logic [15:0] SLOW_MULT = 16'd20;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_CLEAR   = 4'd1;
  localparam state_t ST_ARM     = 4'd2;
  localparam state_t ST_WAIT    = 4'd3;
  localparam state_t ST_SETTLE  = 4'd4;
  localparam state_t ST_CAPTURE = 4'd5;
  localparam state_t ST_SCALE   = 4'd6;
  localparam state_t ST_RANGE   = 4'd7;
  localparam state_t ST_NEXT    = 4'd8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: first flop may go metastable, second resolves it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Sequencer and result stage behind the gate counter: clear, arm, wait for done,
// capture, scale to Hz, auto-range and publish with a one-cycle valid pulse.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned CLR_CYCLES     = 32'd4,
  parameter int unsigned SETTLE_CYCLES  = 32'd2,
  parameter int unsigned TIMEOUT_CYCLES = 32'd4000000,
  parameter int unsigned LOW_THRESH     = 32'd100,
  parameter int unsigned HIGH_THRESH    = 32'd1000000
) (
  input  logic        ref_clk_20M,
  input  logic        cnt_clr,
  input  logic        start,
  input  logic        continuous,
  input  logic        auto_range,
  input  logic        gate_man,
  input  logic        done_in,
  input  logic [31:0] cnt_in,
  output logic        meas_clr_n,
  output logic        gate_sel,
  output logic        busy,
  output logic        freq_valid,
  output logic [31:0] freq_hz,
  output logic [31:0] raw_count,
  output logic        gate_used,
  output logic        ovf,
  output logic        timeout
);

  localparam logic [7:0]  CLR_LAST    = 8'(CLR_CYCLES - 32'd1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES - 32'd1);

  state_t      r_state;
  logic        r_range;
  logic        r_gate;
  logic        r_clr_n;
  logic        r_busy;
  logic        r_valid;
  logic [31:0] r_freq_hz;
  logic [31:0] r_raw_count;
  logic        r_gate_used;
  logic        r_ovf;
  logic        r_timeout;
  logic [31:0] r_raw;
  logic [31:0] r_calc_freq;
  logic        r_calc_ovf;
  logic [7:0]  r_step;
  logic [31:0] r_wait;

  logic        w_done_s;
  logic        w_gate_next;
  logic [15:0] w_mult;
  logic [47:0] w_product;

  sync_2ff u_done_sync (
    .i_clk   (ref_clk_20M),
    .i_rst_n (cnt_clr),
    .i_d     (done_in),
    .o_q     (w_done_s)
  );

  assign w_gate_next = auto_range ? r_range : gate_man;
  assign w_mult      = (r_gate == GATE_FAST) ? FAST_MULT : SLOW_MULT;
  assign w_product   = {16'd0, r_raw} * {32'd0, w_mult};

  // Measurement sequencer; every output is a register updated here.
  always_ff @(posedge ref_clk_20M or negedge cnt_clr) begin
    if (!cnt_clr) begin
      r_state     <= ST_IDLE;
      r_range     <= GATE_FAST;
      r_gate      <= GATE_FAST;
      r_clr_n     <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_freq_hz   <= 32'd0;
      r_raw_count <= 32'd0;
      r_gate_used <= GATE_FAST;
      r_ovf       <= 1'b0;
      r_timeout   <= 1'b0;
      r_raw       <= 32'd0;
      r_calc_freq <= 32'd0;
      r_calc_ovf  <= 1'b0;
      r_step      <= 8'd0;
      r_wait      <= 32'd0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clr_n <= 1'b0;
          if (start) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_gate  <= w_gate_next;
            r_step  <= CLR_LAST;
          end
        end
        ST_CLEAR: begin
          if (r_step == 8'd0) begin
            r_state <= ST_ARM;
            r_clr_n <= 1'b1;
          end else begin
            r_step <= r_step - 8'd1;
          end
        end
        ST_ARM: begin
          r_wait  <= 32'd0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done_s) begin
            r_state <= ST_SETTLE;
            r_step  <= SETTLE_LAST;
          end else if (r_wait == TO_LAST) begin
            r_freq_hz   <= 32'd0;
            r_raw_count <= 32'd0;
            r_ovf       <= 1'b0;
            r_timeout   <= 1'b1;
            r_valid     <= 1'b1;
            r_state     <= ST_NEXT;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        ST_SETTLE: begin
          if (r_step == 8'd0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_step <= r_step - 8'd1;
          end
        end
        ST_CAPTURE: begin
          r_raw   <= cnt_in;
          r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          if (w_product[47:32] != 16'd0) begin
            r_calc_freq <= 32'hFFFF_FFFF;
            r_calc_ovf  <= 1'b1;
          end else begin
            r_calc_freq <= w_product[31:0];
            r_calc_ovf  <= 1'b0;
          end
          r_state <= ST_RANGE;
        end
        ST_RANGE: begin
          // Once the gate is slow this branch cannot fire again, so at most one re-measure.
          if (auto_range && (r_gate == GATE_FAST) && (r_raw < LOW_THRESH)) begin
            r_range <= GATE_SLOW;
            r_gate  <= GATE_SLOW;
            r_clr_n <= 1'b0;
            r_step  <= CLR_LAST;
            r_state <= ST_CLEAR;
          end else begin
            if (auto_range && (r_gate == GATE_SLOW) && (r_raw > HIGH_THRESH)) begin
              r_range <= GATE_FAST;
            end else begin
              r_range <= r_range;
            end
            r_freq_hz   <= r_calc_freq;
            r_raw_count <= r_raw;
            r_gate_used <= r_gate;
            r_ovf       <= r_calc_ovf;
            r_timeout   <= 1'b0;
            r_valid     <= 1'b1;
            r_state     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r_clr_n <= 1'b0;
          if (continuous) begin
            r_gate  <= w_gate_next;
            r_step  <= CLR_LAST;
            r_state <= ST_CLEAR;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_clr_n <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign meas_clr_n = r_clr_n;
  assign gate_sel   = r_gate;
  assign busy       = r_busy;
  assign freq_valid = r_valid;
  assign freq_hz    = r_freq_hz;
  assign raw_count  = r_raw_count;
  assign gate_used  = r_gate_used;
  assign ovf        = r_ovf;
  assign timeout    = r_timeout;

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sequencer and result stage directly downstream of the gate-counting frequency counter.
- Each measurement: issues the counter's clear, selects the gate (50 us fast / 50 ms slow), waits for the counter's done flag, and captures the raw count.
- Scales the count to Hz and publishes the result with a valid pulse; optionally auto-ranges between gates.
- Feeds the DSO measurement register bank.

Parameters:
- CLR_CYCLES, 4: ref_clk cycles meas_clr_n is held low per measurement.
- SETTLE_CYCLES, 2: extra ref_clk cycles after synchronised done, before cnt_in is sampled.
- TIMEOUT_CYCLES, 4000000: max ref_clk cycles in WAIT (200 ms).
- LOW_THRESH, 100: fast-gate count below this triggers a re-measure on the slow gate.
- HIGH_THRESH, 1000000: slow-gate count above this selects the fast gate for the next measurement.
- FAST_MULT, 20000: Hz per count, 50 us gate.
- SLOW_MULT, 20: Hz per count, 50 ms gate.

Ports:
- ref_clk_20M  in  1  20 MHz system clock.
- cnt_clr  in  1  async active-low reset.
- start  in  1  single-cycle pulse; begins one measurement, or a continuous run.
- continuous  in  1  level; while high, re-arm automatically after each result.
- auto_range  in  1  level; enables gate auto-ranging.
- gate_man  in  1  manual gate when auto_range=0 (1=fast).
- done_in  in  1  counter done flag, rx_clk domain (asynchronous here).
- cnt_in  in  32  counter raw count; stable while done_in=1.
- meas_clr_n  out  1  active-low clear to counter.
- gate_sel  out  1  gate select to counter (1=fast 50 us, 0=slow 50 ms).
- busy  out  1  high from start accept until IDLE.
- freq_valid  out  1  one-cycle pulse when the result outputs update.
- freq_hz  out  32  scaled frequency, saturating.
- raw_count  out  32  captured count.
- gate_used  out  1  gate of the published result.
- ovf  out  1  scale saturated.
- timeout  out  1  last measurement timed out.

Behaviour:
- Reset (cnt_clr=0, async) values:
  - meas_clr_n=0, gate_sel=1, busy=0, freq_valid=0.
  - freq_hz=0, raw_count=0, gate_used=1, ovf=0, timeout=0.
  - State=IDLE; range register=fast.
- done_in passes through a 2-flop synchroniser (done_s). cnt_in is only sampled in CAPTURE; no synchroniser on the bus.
- State machine:
  - IDLE: meas_clr_n=0. On start=1, go to CLEAR and set busy=1. gate_sel = range register if auto_range=1, else gate_man.
  - CLEAR: meas_clr_n=0 for CLR_CYCLES cycles, then go to ARM.
  - ARM: meas_clr_n=1; load timeout counter; go to WAIT.
  - WAIT: on done_s=1, go to SETTLE. If the counter reaches TIMEOUT_CYCLES: set freq_hz=0, raw_count=0, timeout=1, ovf=0, pulse freq_valid, then go to NEXT.
  - SETTLE: SETTLE_CYCLES cycles, then go to CAPTURE.
  - CAPTURE: raw_reg <= cnt_in; go to SCALE.
  - SCALE: product = raw_reg × (gate_sel ? FAST_MULT : SLOW_MULT), 48-bit unsigned. If product[47:32] != 0: freq=32'hFFFFFFFF, ovf=1. Go to RANGE.
  - RANGE, with auto_range=1:
    - gate fast and raw < LOW_THRESH: range<=slow, no publish, go to CLEAR (re-measure).
    - gate slow and raw > HIGH_THRESH: range<=fast, publish.
    - otherwise: publish.
  - RANGE, with auto_range=0: always publish.
  - Publish: update freq_hz, raw_count, gate_used, ovf; timeout=0; freq_valid=1 for one cycle. Then go to NEXT.
  - NEXT: if continuous=1, go to CLEAR with the new gate_sel. Else go to IDLE and set busy=0.
- gate_sel changes only on entry to CLEAR; it is stable for the whole measurement.
- start while busy is ignored. Dropping continuous mid-run ends after the current result.
- Reset mid-measurement aborts immediately to reset values; no freq_valid is produced.
- Latency from done_s rising to freq_valid: SETTLE_CYCLES+3 cycles (SETTLE, CAPTURE, SCALE, RANGE).
- Auto-range re-measure adds exactly one extra measurement; it never loops more than once per start.

Decomposition:
- Shared package freq_meas_pkg holds:
  - state enum;
  - FAST_MULT/SLOW_MULT;
  - gate encoding constants (GATE_FAST=1, GATE_SLOW=0).
- One natural sub-module, sync_2ff (done_in synchroniser), reusable elsewhere in the design.
- Multiplier stays inline.

Test Plan:
- Manual fast gate: gate_man=1, counter model returns 50 (1 MHz input) -> freq_hz=1000000, gate_used=1, ovf=0. freq_valid arrives SETTLE_CYCLES+3 cycles after done_s.
- Manual slow gate: gate_man=0, cnt_in=50000 -> freq_hz=1000000, raw_count=50000, gate_used=0.
- Auto-range down: range=fast, first cnt_in=0 -> no freq_valid; meas_clr_n pulses low 4 cycles; gate_sel=0. Second cnt_in=50 -> freq_hz=1000, gate_used=0.
- Overflow: slow gate, cnt_in=32'hFFFFFFFF, auto_range=0 -> freq_hz=32'hFFFFFFFF, ovf=1.
- Timeout: done_in held 0 -> after 4000000 cycles freq_valid=1, freq_hz=0, timeout=1. With continuous=0, busy falls.
- Continuous plus reset: continuous=1 over three measurements -> three freq_valid pulses. Assert cnt_clr=0 during WAIT -> all outputs return to reset values, no pulse, busy=0.
